hazard_tracker: RTL and testbench

Pipeline hazard tracker for the 5-stage MIPS core. It consumes the per-instruction register-use descriptor produced in the D stage (source addresses with Tuse, destination address with Tnew). It tracks each in-flight producer's destination and remaining Tnew through E, M and W, and drives the D-stage stall and the D-stage forwarding selects. Sits in the controller beside the D-stage decoder; the datapath obeys its outputs.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_src_check.sv | 45 ++++
 rtl/hazard_tracker.sv | 89 ++++++++
 tb/tb_hazard_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the D-stage decoder and the hazard tracker.
// Holds the forward-select codes, the address and Tuse/Tnew widths, and the
// per-instruction Tuse/Tnew encodings. Keeping them here means the decoder
// and the tracker always agree on them.
package hazard_pkg;

  localparam int NREG_W = 5;
  localparam int T_W    = 2;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // Tnew: cycles after entering E until the result can be forwarded
  localparam logic [T_W-1:0] TNEW_ALU = 2'd1;  // addu, subu, ori, sll
  localparam logic [T_W-1:0] TNEW_LW  = 2'd2;
  localparam logic [T_W-1:0] TNEW_JAL = 2'd0;
  localparam logic [T_W-1:0] TNEW_LUI = 2'd0;

  // Tuse: cycles after D until the source operand is consumed
  localparam logic [T_W-1:0] TUSE_BRANCH = 2'd0;  // beq, jr
  localparam logic [T_W-1:0] TUSE_ALU    = 2'd1;
  localparam logic [T_W-1:0] TUSE_SW_RT  = 2'd2;

endpackage

// File: rtl/hazard_src_check.sv
// hazard_src_check
// Combinational hazard check and forward select for one D-stage source.
// Ports:
//   a_d, tuse_d      source address and Tuse from the D stage
//   a3_e, tnew_e     E-stage tracked destination / remaining Tnew
//   a3_m, tnew_m     M-stage tracked destination / remaining Tnew
//   a3_w             W-stage tracked destination (its Tnew is always 0)
//   hazard           source needs a value that will not be ready in time
//   fwd              forward select (FWD_RF/E/M/W)
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int NREG_W = hazard_pkg::NREG_W,
  parameter int T_W    = hazard_pkg::T_W
) (
  input  logic [NREG_W-1:0] a_d,
  input  logic [T_W-1:0]    tuse_d,
  input  logic [NREG_W-1:0] a3_e,
  input  logic [T_W-1:0]    tnew_e,
  input  logic [NREG_W-1:0] a3_m,
  input  logic [T_W-1:0]    tnew_m,
  input  logic [NREG_W-1:0] a3_w,
  output logic              hazard,
  output logic [1:0]        fwd
);

  always_comb begin
    hazard = 1'b0;
    fwd    = FWD_RF;
    if (a_d != '0) begin
      hazard = ((a_d == a3_e) && (tnew_e > tuse_d)) ||
               ((a_d == a3_m) && (tnew_m > tuse_d));
      // The youngest matching stage owns the register. If its value is not
      // ready yet, an older copy is stale, so fall back to RF (stall covers it).
      if (a_d == a3_e) begin
        fwd = (tnew_e == '0) ? FWD_E : FWD_RF;
      end else if (a_d == a3_m) begin
        fwd = (tnew_m == '0) ? FWD_M : FWD_RF;
      end else if (a_d == a3_w) begin
        fwd = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker
// Tracks in-flight producers through E, M and W and drives the D-stage stall
// and forwarding selects for the 5-stage MIPS core.
// Ports:
//   clk                         core clock, rising edge
//   reset                       synchronous, active-low
//   a1_d, tuse1_d               D-stage source 1 address / Tuse
//   a2_d, tuse2_d               D-stage source 2 address / Tuse
//   a3_d, tnew_d                D-stage destination / Tnew (a3_d=0: none)
//   stall                       hold PC and D, bubble into E
//   fwd1_d, fwd2_d              forward selects: 0 RF, 1 E, 2 M, 3 W
//   a3_e, a3_m, a3_w            tracked destinations
//   tnew_e, tnew_m              tracked remaining Tnew
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int NREG_W = hazard_pkg::NREG_W,
  parameter int T_W    = hazard_pkg::T_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREG_W-1:0] a1_d,
  input  logic [T_W-1:0]    tuse1_d,
  input  logic [NREG_W-1:0] a2_d,
  input  logic [T_W-1:0]    tuse2_d,
  input  logic [NREG_W-1:0] a3_d,
  input  logic [T_W-1:0]    tnew_d,
  output logic              stall,
  output logic [1:0]        fwd1_d,
  output logic [1:0]        fwd2_d,
  output logic [NREG_W-1:0] a3_e,
  output logic [NREG_W-1:0] a3_m,
  output logic [NREG_W-1:0] a3_w,
  output logic [T_W-1:0]    tnew_e,
  output logic [T_W-1:0]    tnew_m
);

  logic haz1;
  logic haz2;

  hazard_src_check #(.NREG_W(NREG_W), .T_W(T_W)) u_src1 (
    .a_d    (a1_d),
    .tuse_d (tuse1_d),
    .a3_e   (a3_e),
    .tnew_e (tnew_e),
    .a3_m   (a3_m),
    .tnew_m (tnew_m),
    .a3_w   (a3_w),
    .hazard (haz1),
    .fwd    (fwd1_d)
  );

  hazard_src_check #(.NREG_W(NREG_W), .T_W(T_W)) u_src2 (
    .a_d    (a2_d),
    .tuse_d (tuse2_d),
    .a3_e   (a3_e),
    .tnew_e (tnew_e),
    .a3_m   (a3_m),
    .tnew_m (tnew_m),
    .a3_w   (a3_w),
    .hazard (haz2),
    .fwd    (fwd2_d)
  );

  assign stall = haz1 | haz2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a3_e   <= '0;
      tnew_e <= '0;
      a3_m   <= '0;
      tnew_m <= '0;
      a3_w   <= '0;
    end else begin
      a3_w   <= a3_m;
      a3_m   <= a3_e;
      // Tnew counts down once per stage and saturates at 0
      tnew_m <= (tnew_e == '0) ? '0 : tnew_e - T_W'(1);
      if (stall) begin
        a3_e   <= '0;
        tnew_e <= '0;
      end else begin
        a3_e   <= a3_d;
        tnew_e <= tnew_d;
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker
// Scoreboard bench for hazard_tracker. The reference model keeps a history of
// instructions accepted out of D (cycle number, destination, Tnew); the
// producer in each stage is found by its issue cycle, and remaining Tnew is
// computed from its age. A monitor pops expectations on the falling edge.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] a1_d, a2_d, a3_d;
  logic [1:0] tuse1_d, tuse2_d, tnew_d;
  logic       stall;
  logic [1:0] fwd1_d, fwd2_d;
  logic [4:0] a3_e, a3_m, a3_w;
  logic [1:0] tnew_e, tnew_m;

  hazard_tracker dut (
    .clk     (clk),
    .reset   (reset),
    .a1_d    (a1_d),
    .tuse1_d (tuse1_d),
    .a2_d    (a2_d),
    .tuse2_d (tuse2_d),
    .a3_d    (a3_d),
    .tnew_d  (tnew_d),
    .stall   (stall),
    .fwd1_d  (fwd1_d),
    .fwd2_d  (fwd2_d),
    .a3_e    (a3_e),
    .a3_m    (a3_m),
    .a3_w    (a3_w),
    .tnew_e  (tnew_e),
    .tnew_m  (tnew_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int dest;
    int tnew;
  } prod_t;

  typedef struct {
    int stall;
    int fwd1;
    int fwd2;
    int a3e;
    int a3m;
    int a3w;
    int tne;
    int tnm;
  } exp_t;

  prod_t hist[$];
  exp_t  exp_q[$];
  int    cur = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  // Producer accepted out of D in cycle c, if any (else a bubble / nothing)
  function automatic void lookup(input int c, output int dest, output int rem, input int t);
    dest = 0;
    rem  = 0;
    foreach (hist[i]) begin
      if (hist[i].cyc == c) begin
        dest = hist[i].dest;
        rem  = hist[i].tnew - (t - c - 1);
        if (rem < 0) rem = 0;
      end
    end
  endfunction

  function automatic exp_t compute_exp(input int t, input int a1, input int tu1,
                                       input int a2, input int tu2);
    exp_t e;
    int d[3];
    int r[3];
    int a[2];
    int tu[2];
    int f[2];
    int hz;
    for (int s = 0; s < 3; s++) lookup(t - 1 - s, d[s], r[s], t);
    a[0] = a1; a[1] = a2; tu[0] = tu1; tu[1] = tu2;
    hz = 0;
    for (int k = 0; k < 2; k++) begin
      f[k] = 0;
      if (a[k] != 0) begin
        if ((a[k] == d[0] && r[0] > tu[k]) || (a[k] == d[1] && r[1] > tu[k])) hz = 1;
        for (int s = 2; s >= 0; s--) begin
          // Scanning oldest to youngest so the youngest match wins
          if (d[s] == a[k]) f[k] = (r[s] == 0) ? s + 1 : 0;
        end
      end
    end
    e.stall = hz;
    e.fwd1  = f[0];
    e.fwd2  = f[1];
    e.a3e   = d[0];
    e.a3m   = d[1];
    e.a3w   = d[2];
    e.tne   = r[0];
    e.tnm   = r[1];
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cur, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall",  int'(stall),  e.stall);
      check("fwd1_d", int'(fwd1_d), e.fwd1);
      check("fwd2_d", int'(fwd2_d), e.fwd2);
      check("a3_e",   int'(a3_e),   e.a3e);
      check("a3_m",   int'(a3_m),   e.a3m);
      check("a3_w",   int'(a3_w),   e.a3w);
      check("tnew_e", int'(tnew_e), e.tne);
      check("tnew_m", int'(tnew_m), e.tnm);
    end
  end

  task automatic step(input bit rst, input int a1, input int tu1, input int a2,
                      input int tu2, input int a3, input int tn);
    exp_t e;
    reset   = rst;
    a1_d    = 5'(a1);
    tuse1_d = 2'(tu1);
    a2_d    = 5'(a2);
    tuse2_d = 2'(tu2);
    a3_d    = 5'(a3);
    tnew_d  = 2'(tn);
    e = compute_exp(cur, a1, tu1, a2, tu2);
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      hist.delete();
    end else if (e.stall == 0) begin
      hist.push_back('{cyc: cur, dest: a3, tnew: tn});
    end
    while (hist.size() > 0 && hist[0].cyc < cur - 4) void'(hist.pop_front());
    cur++;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int regs[5];
    regs[0] = 0; regs[1] = 1; regs[2] = 2; regs[3] = 3; regs[4] = 31;
    reset = 1'b0;
    a1_d = 5'd8; tuse1_d = 2'd0; a2_d = '0; tuse2_d = '0; a3_d = '0; tnew_d = '0;
    @(posedge clk);
    #1;
    cur = 1;

    // reset held low with a consumer of $8 in D, then release
    step(0, 8, 0, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // lw $8 then addu reading $8
    step(1, 0, 0, 0, 0, 8, 2);
    step(1, 8, 1, 0, 0, 9, 1);
    step(1, 8, 1, 0, 0, 9, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // addu $5 then beq $5
    step(1, 0, 0, 0, 0, 5, 1);
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // jal then jr $31
    step(1, 0, 0, 0, 0, 31, 0);
    step(1, 31, 0, 0, 0, 0, 0);
    // $9 in M (ready) and in E (not ready); sw-style consumer tuse2=2
    step(1, 0, 0, 0, 0, 9, 1);
    step(1, 0, 0, 0, 0, 9, 1);
    step(1, 0, 0, 9, 2, 0, 0);
    // consumer of $0 behind a bubble
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // reset asserted during a stall
    step(1, 0, 0, 0, 0, 8, 2);
    step(0, 8, 0, 0, 0, 0, 0);
    step(1, 8, 0, 0, 0, 0, 0);
    step(1, 8, 0, 8, 1, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0),
           regs[$urandom_range(0, 4)], int'($urandom_range(0, 2)),
           regs[$urandom_range(0, 4)], int'($urandom_range(0, 2)),
           regs[$urandom_range(0, 4)], int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
